// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter for the shared register-file write port, plus a pending-write
// scoreboard that issue logic queries to stall reads of stale operands.
module rf_wb_arbiter (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req0_valid_i,
    input  logic [4:0]  req0_rd_i,
    input  logic [31:0] req0_data_i,
    output logic        req0_ready_o,
    input  logic        req1_valid_i,
    input  logic [4:0]  req1_rd_i,
    input  logic [31:0] req1_data_i,
    output logic        req1_ready_o,
    input  logic        mark_valid_i,
    input  logic [4:0]  mark_rd_i,
    input  logic [4:0]  rs1_index_i,
    input  logic [4:0]  rs2_index_i,
    output logic        rs1_busy_o,
    output logic        rs2_busy_o,
    output logic        wb_en_o,
    output logic [4:0]  rd_index_o,
    output logic [31:0] wb_data_o
);

    logic        last_grant_q, last_grant_d;
    logic        wb_en_q, wb_en_d;
    logic [4:0]  rd_index_q, rd_index_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [31:0] busy_q, busy_d;
    logic        gnt0, gnt1;

    // Grants depend only on the valids and the round-robin pointer.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst_i) begin
            if (req0_valid_i && req1_valid_i) begin
                gnt0 = last_grant_q;
                gnt1 = !last_grant_q;
            end else begin
                gnt0 = req0_valid_i;
                gnt1 = req1_valid_i;
            end
        end
    end

    assign req0_ready_o = gnt0;
    assign req1_ready_o = gnt1;

    always_comb begin
        last_grant_d = last_grant_q;
        wb_en_d      = 1'b0;
        rd_index_d   = rd_index_q;
        wb_data_d    = wb_data_q;
        if (gnt0) begin
            last_grant_d = 1'b0;
            wb_en_d      = |req0_rd_i;
            rd_index_d   = req0_rd_i;
            wb_data_d    = req0_data_i;
        end else if (gnt1) begin
            last_grant_d = 1'b1;
            wb_en_d      = |req1_rd_i;
            rd_index_d   = req1_rd_i;
            wb_data_d    = req1_data_i;
        end
    end

    // Clear on the register-file write edge; a same-edge set wins since it is a newer producer.
    always_comb begin
        busy_d = busy_q;
        if (wb_en_q) begin
            busy_d[rd_index_q] = 1'b0;
        end
        if (mark_valid_i && (mark_rd_i != 5'd0)) begin
            busy_d[mark_rd_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_grant_q <= 1'b1;
            wb_en_q      <= 1'b0;
            rd_index_q   <= 5'd0;
            wb_data_q    <= 32'd0;
            busy_q       <= 32'd0;
        end else begin
            last_grant_q <= last_grant_d;
            wb_en_q      <= wb_en_d;
            rd_index_q   <= rd_index_d;
            wb_data_q    <= wb_data_d;
            busy_q       <= busy_d;
        end
    end

    assign rs1_busy_o = busy_q[rs1_index_i];
    assign rs2_busy_o = busy_q[rs2_index_i];
    assign wb_en_o    = wb_en_q;
    assign rd_index_o = rd_index_q;
    assign wb_data_o  = wb_data_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: reset, single write, contention, x0 writes,
// scoreboard set/clear collisions and held-valid arbitration.
module tb_rf_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid;
    logic [4:0]  req0_rd;
    logic [31:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [4:0]  req1_rd;
    logic [31:0] req1_data;
    logic        req1_ready;
    logic        mark_valid;
    logic [4:0]  mark_rd;
    logic [4:0]  rs1_index;
    logic [4:0]  rs2_index;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        wb_en;
    logic [4:0]  rd_index;
    logic [31:0] wb_data;

    int n_checks = 0;
    int n_fail   = 0;

    rf_wb_arbiter dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req0_valid_i (req0_valid),
        .req0_rd_i    (req0_rd),
        .req0_data_i  (req0_data),
        .req0_ready_o (req0_ready),
        .req1_valid_i (req1_valid),
        .req1_rd_i    (req1_rd),
        .req1_data_i  (req1_data),
        .req1_ready_o (req1_ready),
        .mark_valid_i (mark_valid),
        .mark_rd_i    (mark_rd),
        .rs1_index_i  (rs1_index),
        .rs2_index_i  (rs2_index),
        .rs1_busy_o   (rs1_busy),
        .rs2_busy_o   (rs2_busy),
        .wb_en_o      (wb_en),
        .rd_index_o   (rd_index),
        .wb_data_o    (wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1);
    end

    // Inputs change 1ns after the rising edge; outputs are sampled between edges.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_rd = 5'd0; req0_data = 32'd0;
        req1_valid = 1'b0; req1_rd = 5'd0; req1_data = 32'd0;
        mark_valid = 1'b0; mark_rd = 5'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        // Held in reset from time 0
        #1;
        n_checks++;
        if (wb_en !== 1'b0 || rd_index !== 5'd0 || wb_data !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_init: got wb_en=%b rd=%0d data=%h, expected 0/0/0",
                     wb_en, rd_index, wb_data);
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        n_checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: got r0=%b r1=%b, expected 0/0", req0_ready, req1_ready);
        end
        idle_inputs();
        tick();
        rst = 1'b0;
        // Build state with a pending write, then reset asynchronously mid-cycle
        mark_valid = 1'b1; mark_rd = 5'd3;
        req0_valid = 1'b1; req0_rd = 5'd3; req0_data = 32'h0000_00AA;
        tick();
        idle_inputs();
        rs1_index = 5'd3;
        #1;
        n_checks++;
        if (wb_en !== 1'b1 || rs1_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pre: got wb_en=%b busy3=%b, expected 1/1", wb_en, rs1_busy);
        end
        #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if (wb_en !== 1'b0 || rd_index !== 5'd0 || wb_data !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_async: got wb_en=%b rd=%0d data=%h, expected 0/0/0",
                     wb_en, rd_index, wb_data);
        end
        for (int i = 0; i < 32; i++) begin
            rs1_index = i[4:0];
            #0.1;
            n_checks++;
            if (rs1_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_busy[%0d]: got %b, expected 0", i, rs1_busy);
            end
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_single_write();
        mark_valid = 1'b1; mark_rd = 5'd5;
        tick();
        mark_valid = 1'b0;
        rs1_index = 5'd5;
        req0_valid = 1'b1; req0_rd = 5'd5; req0_data = 32'hDEAD_BEEF;
        #1;
        n_checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0 || rs1_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_grant: got r0=%b r1=%b busy5=%b, expected 1/0/1",
                     req0_ready, req1_ready, rs1_busy);
        end
        tick();
        req0_valid = 1'b0;
        #1;
        n_checks++;
        if (wb_en !== 1'b1 || rd_index !== 5'd5 || wb_data !== 32'hDEAD_BEEF || rs1_busy !== 1'b1)
        begin
            n_fail++;
            $display("FAIL single_wb: got wb_en=%b rd=%0d data=%h busy5=%b, expected 1/5/deadbeef/1",
                     wb_en, rd_index, wb_data, rs1_busy);
        end
        tick();
        #1;
        n_checks++;
        if (wb_en !== 1'b0 || rd_index !== 5'd5 || wb_data !== 32'hDEAD_BEEF || rs1_busy !== 1'b0)
        begin
            n_fail++;
            $display("FAIL single_after: got wb_en=%b rd=%0d data=%h busy5=%b, expected 0/5/deadbeef/0",
                     wb_en, rd_index, wb_data, rs1_busy);
        end
    endtask

    task automatic test_contention();
        logic [4:0]  exp_rd;
        logic [31:0] exp_data;
        do_reset();
        req0_valid = 1'b1; req0_rd = 5'd1; req0_data = 32'h1111_0001;
        req1_valid = 1'b1; req1_rd = 5'd2; req1_data = 32'h2222_0002;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_checks++;
            if (req0_ready !== (k % 2 == 0) || req1_ready !== (k % 2 == 1)) begin
                n_fail++;
                $display("FAIL contention_grant[%0d]: got r0=%b r1=%b, expected r0=%b r1=%b",
                         k, req0_ready, req1_ready, (k % 2 == 0), (k % 2 == 1));
            end
            tick();
            exp_rd   = (k % 2 == 0) ? 5'd1 : 5'd2;
            exp_data = (k % 2 == 0) ? 32'h1111_0001 : 32'h2222_0002;
            n_checks++;
            if (wb_en !== 1'b1 || rd_index !== exp_rd || wb_data !== exp_data) begin
                n_fail++;
                $display("FAIL contention_wb[%0d]: got wb_en=%b rd=%0d data=%h, expected 1/%0d/%h",
                         k, wb_en, rd_index, wb_data, exp_rd, exp_data);
            end
        end
        idle_inputs();
        tick();
        n_checks++;
        if (wb_en !== 1'b0) begin
            n_fail++;
            $display("FAIL contention_idle: got wb_en=%b, expected 0", wb_en);
        end
    endtask

    task automatic test_x0_write();
        req1_valid = 1'b1; req1_rd = 5'd0; req1_data = 32'h0000_1234;
        mark_valid = 1'b1; mark_rd = 5'd0;
        rs1_index = 5'd0; rs2_index = 5'd0;
        #1;
        n_checks++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL x0_grant: got r0=%b r1=%b, expected 0/1", req0_ready, req1_ready);
        end
        tick();
        idle_inputs();
        #1;
        n_checks++;
        if (wb_en !== 1'b0 || rd_index !== 5'd0 || wb_data !== 32'h0000_1234 || rs1_busy !== 1'b0)
        begin
            n_fail++;
            $display("FAIL x0_wb: got wb_en=%b rd=%0d data=%h busy0=%b, expected 0/0/00001234/0",
                     wb_en, rd_index, wb_data, rs1_busy);
        end
    endtask

    task automatic test_collision();
        // Same-index set and clear: set wins
        mark_valid = 1'b1; mark_rd = 5'd7;
        tick();
        mark_valid = 1'b0;
        req0_valid = 1'b1; req0_rd = 5'd7; req0_data = 32'h7777_0007;
        tick();
        req0_valid = 1'b0;
        mark_valid = 1'b1; mark_rd = 5'd7;
        rs1_index = 5'd7;
        tick();
        mark_valid = 1'b0;
        #1;
        n_checks++;
        if (rs1_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL collide_same: got busy7=%b, expected 1", rs1_busy);
        end
        // Drain the newer producer
        req0_valid = 1'b1; req0_rd = 5'd7; req0_data = 32'h7777_0008;
        tick();
        req0_valid = 1'b0;
        tick();
        n_checks++;
        if (rs1_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL collide_drain: got busy7=%b, expected 0", rs1_busy);
        end
        // Different indices on the same edge: both take effect
        mark_valid = 1'b1; mark_rd = 5'd7;
        tick();
        mark_valid = 1'b0;
        req0_valid = 1'b1; req0_rd = 5'd7; req0_data = 32'h7777_0009;
        tick();
        req0_valid = 1'b0;
        mark_valid = 1'b1; mark_rd = 5'd9;
        rs2_index = 5'd9;
        tick();
        mark_valid = 1'b0;
        #1;
        n_checks++;
        if (rs1_busy !== 1'b0 || rs2_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL collide_diff: got busy7=%b busy9=%b, expected 0/1", rs1_busy, rs2_busy);
        end
    endtask

    task automatic test_held_valid();
        // A req1 transfer leaves the pointer at 1 so req0 wins the next tie
        req1_valid = 1'b1; req1_rd = 5'd10; req1_data = 32'hAAAA_000A;
        tick();
        req1_valid = 1'b1; req1_rd = 5'd12; req1_data = 32'hCCCC_000C;
        req0_valid = 1'b1; req0_rd = 5'd11; req0_data = 32'hBBBB_000B;
        #1;
        n_checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL held_tie: got r0=%b r1=%b, expected 1/0", req0_ready, req1_ready);
        end
        tick();
        req0_valid = 1'b0;
        #1;
        n_checks++;
        if (req1_ready !== 1'b1 || wb_en !== 1'b1 || rd_index !== 5'd11 ||
            wb_data !== 32'hBBBB_000B) begin
            n_fail++;
            $display("FAIL held_first: got r1=%b wb_en=%b rd=%0d data=%h, expected 1/1/11/bbbb000b",
                     req1_ready, wb_en, rd_index, wb_data);
        end
        tick();
        req1_valid = 1'b0;
        #1;
        n_checks++;
        if (wb_en !== 1'b1 || rd_index !== 5'd12 || wb_data !== 32'hCCCC_000C) begin
            n_fail++;
            $display("FAIL held_second: got wb_en=%b rd=%0d data=%h, expected 1/12/cccc000c",
                     wb_en, rd_index, wb_data);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        rs1_index = 5'd0;
        rs2_index = 5'd0;
        test_reset();
        test_single_write();
        test_contention();
        test_x0_write();
        test_collision();
        test_held_valid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
